// File: rtl/regfile_pkg.sv
// Shared write-back types and register-file geometry for the pipeline.
package regfile_pkg;

  localparam int DW     = 32;  // write-back data width
  localparam int AW     = 4;   // register index width
  localparam int NREG   = 15;  // writable registers 0..NREG-1
  localparam int PC_IDX = 15;  // PC index: never written, never scoreboarded

  // One write-back request: destination register plus result data.
  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small skid FIFO that buffers EXE write-back requests while MEM owns the port.
module wb_skid_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t          mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});

  // Storage and write pointer: store on push, pointer wraps at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{dest: {AW{1'b0}}, data: {DW{1'b0}}};
      end
      wr_ptr_r <= {PW{1'b0}};
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
      wr_ptr_r        <= (wr_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer: advance on pop, wraps at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
    end else if (pop) begin
      rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy count: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write-back port between MEM (direct)
// and EXE (via skid FIFO), with anti-starvation for EXE, and keeps a
// per-register count of outstanding writes for ID-stage RAW hazard detection.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          exe_valid,
  output logic          exe_ready,
  input  logic [AW-1:0] exe_dest,
  input  logic [DW-1:0] exe_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_dest,
  input  logic [AW-1:0] SRC1,
  input  logic [AW-1:0] SRC2,
  output logic          hazard,
  output logic          WriteBackEn,
  output logic [AW-1:0] Dest_WB,
  output logic [DW-1:0] Result_WB
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wb_req_t          push_req_s;
  wb_req_t          head_s;
  wb_req_t          win_req_s;
  logic             push_s;
  logic             empty_s;
  logic [FCW-1:0]   fifo_count_s;
  logic             grant_exe_s;
  logic             grant_mem_s;
  logic             commit_s;
  logic [SCW-1:0]   starve_r;
  logic [SCW-1:0]   starve_nxt_s;
  logic [CNT_W-1:0] cnt_r     [NREG];
  logic [CNT_W-1:0] cnt_nxt_s [NREG];
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  dec_s;
  logic             iss_ready_s;
  logic             hazard_s;
  logic             wb_en_r;
  logic [AW-1:0]    dest_r;
  logic [DW-1:0]    data_r;

  assign exe_ready  = (fifo_count_s < FCW'(FIFO_DEPTH));
  assign push_s     = exe_valid & exe_ready;
  assign push_req_s = {exe_dest, exe_data};

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_req_s),
    .pop       (grant_exe_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (empty_s)
  );

  // Arbiter: MEM first unless EXE has waited STARVE_MAX MEM grants; also next starve count.
  always_comb begin
    grant_exe_s  = 1'b0;
    grant_mem_s  = 1'b0;
    win_req_s    = head_s;
    starve_nxt_s = starve_r;
    if (!empty_s && ((starve_r == SCW'(STARVE_MAX)) || !mem_valid)) begin
      grant_exe_s = 1'b1;
      win_req_s   = head_s;
    end else if (mem_valid) begin
      grant_mem_s = 1'b1;
      win_req_s   = {mem_dest, mem_data};
    end else begin
      win_req_s   = head_s;
    end
    if (empty_s || grant_exe_s) begin
      starve_nxt_s = {SCW{1'b0}};
    end else if (grant_mem_s && (starve_r != SCW'(STARVE_MAX))) begin
      starve_nxt_s = starve_r + SCW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  assign mem_ready = grant_mem_s;
  // Writes to the PC index are consumed but dropped here.
  assign commit_s  = (grant_exe_s | grant_mem_s) && (win_req_s.dest < AW'(NREG));

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {SCW{1'b0}};
    end else begin
      starve_r <= starve_nxt_s;
    end
  end

  // Write-back port registers, sampled by the register file on the following negedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_r <= 1'b0;
      dest_r  <= {AW{1'b0}};
      data_r  <= {DW{1'b0}};
    end else if (commit_s) begin
      wb_en_r <= 1'b1;
      dest_r  <= win_req_s.dest;
      data_r  <= win_req_s.data;
    end else begin
      wb_en_r <= 1'b0;
      dest_r  <= dest_r;
      data_r  <= data_r;
    end
  end

  assign WriteBackEn = wb_en_r;
  assign Dest_WB     = dest_r;
  assign Result_WB   = data_r;

  // Scoreboard lookups: reservation room for iss_dest and pending writes on the sources.
  always_comb begin
    iss_ready_s = 1'b1;
    hazard_s    = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if ((iss_dest == AW'(r)) && (cnt_r[r] == CNT_MAX)) begin
        iss_ready_s = 1'b0;
      end else begin
        iss_ready_s = iss_ready_s;
      end
      if (((SRC1 == AW'(r)) || (SRC2 == AW'(r))) && (cnt_r[r] != {CNT_W{1'b0}})) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign iss_ready = iss_ready_s;
  assign hazard    = hazard_s;

  // Scoreboard next state: reserve on issue, release on commit, never under/overflow.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_s[r]     = iss_valid && iss_ready_s && (iss_dest == AW'(r));
      dec_s[r]     = commit_s && (win_req_s.dest == AW'(r)) && (cnt_r[r] != {CNT_W{1'b0}});
      cnt_nxt_s[r] = cnt_r[r];
      case ({inc_s[r], dec_s[r]})
        2'b10:   cnt_nxt_s[r] = cnt_r[r] + CNT_W'(1);
        2'b01:   cnt_nxt_s[r] = cnt_r[r] - CNT_W'(1);
        default: cnt_nxt_s[r] = cnt_r[r];
      endcase
    end
  end

  // Scoreboard count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
    end
  end

endmodule
